// File: rtl/crc_field.sv
// CAN CRC field generator.
// Accumulates the CRC-15 over the unstuffed frame bits, then shifts the
// 15-bit CRC out MSB first on sample points, followed by one recessive
// delimiter bit. Dropping enable or Tx_request aborts back to IDLE.
module crc_field (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_point,
    input  logic        Tx_request,
    input  logic        crc_bit_in,
    input  logic        crc_bit_valid,
    input  logic        data_complete,
    output logic        crc_bit,
    output logic [3:0]  bit_counter,
    output logic [14:0] crc_reg,
    output logic        crc_complete
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCUM    = 3'd1,
        SEND     = 3'd2,
        DELIM    = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    localparam logic [14:0] CRC_POLY = 15'h4599;
    localparam logic [3:0]  LAST_BIT = 4'd14;

    state_t      state_reg;
    state_t      state_next;
    logic        run;
    logic        crc_feedback;
    logic [14:0] crc_step;
    logic [14:0] crc_msb_first;

    // The frame only proceeds while both enable and the request are held.
    assign run = enable & Tx_request;

    // One CRC-15 shift step for the incoming bit.
    assign crc_feedback = crc_bit_in ^ crc_reg[14];
    assign crc_step     = {crc_reg[13:0], 1'b0} ^ (crc_feedback ? CRC_POLY : 15'h0000);

    // Bit-reversed view of the CRC so the counter indexes it MSB first.
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_msb_first
            assign crc_msb_first[gi] = crc_reg[14-gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; any loss of run aborts straight to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (run) state_next = ACCUM;
            end
            ACCUM: begin
                if (!run)               state_next = IDLE;
                else if (data_complete) state_next = SEND;
            end
            SEND: begin
                if (!run)                                       state_next = IDLE;
                else if (sample_point && bit_counter == LAST_BIT) state_next = DELIM;
            end
            DELIM: begin
                if (!run)              state_next = IDLE;
                else if (sample_point) state_next = COMPLETE;
            end
            COMPLETE: begin
                if (!run) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // CRC accumulator: cleared on frame start, updated only while accumulating,
    // frozen otherwise (including across an abort).
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_reg <= 15'h0000;
        end else if (state_reg == IDLE && run) begin
            crc_reg <= 15'h0000;
        end else if (state_reg == ACCUM && run && crc_bit_valid) begin
            crc_reg <= crc_step;
        end
    end

    // Transmit bit index: advances on sample points in SEND, saturates at the
    // last CRC bit, and is zero outside the send/delimiter/complete phases.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_counter <= 4'd0;
        end else begin
            case (state_reg)
                SEND: begin
                    if (!run)
                        bit_counter <= 4'd0;
                    else if (sample_point && bit_counter != LAST_BIT)
                        bit_counter <= bit_counter + 4'd1;
                end
                DELIM, COMPLETE: begin
                    if (!run) bit_counter <= 4'd0;
                end
                default: bit_counter <= 4'd0;
            endcase
        end
    end

    // Output decode: recessive everywhere except while shifting the CRC.
    always_comb begin
        crc_bit      = 1'b1;
        crc_complete = 1'b0;
        case (state_reg)
            SEND:     crc_bit      = crc_msb_first[bit_counter];
            COMPLETE: crc_complete = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: doc/crc_field.md
CRC_FIELD -- requirements
Module: crc_field

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  block enable; low forces IDLE.
- sample_point  input  1  one-cycle CAN bit-timing strobe; advances transmitted bits.
- Tx_request  input  1  frame transmission request, held for the whole frame.
- crc_bit_in  input  1  unstuffed frame bit (SOF through last data bit) to accumulate into the CRC.
- crc_bit_valid  input  1  one-cycle strobe qualifying crc_bit_in.
- data_complete  input  1  from the data field stage; high when the data field is finished.
- crc_bit  output  1  serial CRC/delimiter bit to the bus mux (1 = recessive).
- bit_counter  output  4  index of the CRC bit currently driven (0..14).
- crc_reg  output  15  running/final CRC-15 value.
- crc_complete  output  1  CRC sequence and delimiter finished.

Function
REQ-002 The block SHALL implement the states IDLE, ACCUM, SEND, DELIM and COMPLETE.
REQ-003 In IDLE with enable=1 and Tx_request=1, the block SHALL clear crc_reg to 0 and enter ACCUM on the next clock.
REQ-004 In ACCUM, every cycle with crc_bit_valid=1 SHALL update crc_reg as follows:
- nxt = crc_bit_in XOR crc_reg[14]
- crc_reg = {crc_reg[13:0], 0}
- if nxt = 1, crc_reg is XORed with 15'h4599.
REQ-005 crc_bit_valid SHALL be ignored in every state except ACCUM.
REQ-006 In ACCUM, data_complete=1 SHALL move the block to SEND on that clock edge, with bit_counter=0.
- If crc_bit_valid is also high in that cycle, its update SHALL be included in crc_reg.
REQ-007 crc_reg SHALL be frozen during SEND, DELIM and COMPLETE.
REQ-008 In SEND, crc_bit SHALL equal crc_reg[14 - bit_counter], so the CRC goes out MSB first.
- The value SHALL be valid from the first cycle in SEND.
REQ-009 In SEND, each sample_point SHALL increment bit_counter.
- A sample_point coinciding with the ACCUM->SEND transition SHALL NOT count.
REQ-010 A sample_point in SEND with bit_counter=14 SHALL move the block to DELIM.
- bit_counter SHALL hold at 14.
REQ-011 In DELIM, crc_bit SHALL be 1; the next sample_point SHALL move the block to COMPLETE.
REQ-012 In COMPLETE, crc_complete SHALL be 1 and crc_bit SHALL be 1.
- The block SHALL remain in COMPLETE until Tx_request=0, then go to IDLE.
REQ-013 In IDLE and ACCUM, crc_bit SHALL be 1 and crc_complete SHALL be 0.
REQ-014 enable=0 or Tx_request=0 in any state other than IDLE SHALL abort to IDLE on the next clock.
- On abort: bit_counter=0, crc_complete=0, crc_bit=1; crc_reg retains its value.
REQ-015 A frame that aborts SHALL restart from REQ-003; no partial CRC carries over.
REQ-016 bit_counter SHALL never exceed 14 and SHALL NOT wrap.

Reset
REQ-017 With reset=1 at a clock edge, the block SHALL set:
- state IDLE, crc_reg=15'h0000, bit_counter=0, crc_bit=1, crc_complete=0.
REQ-018 Reset SHALL take priority over all other inputs, including mid-SEND; outputs take reset values on the same edge.
REQ-019 The block SHALL have no asynchronous behaviour.

Verification
REQ-020 Single-bit CRC: start frame, one strobe with crc_bit_in=1 -> crc_reg=15'h4599.
REQ-021 Two-bit CRC: strobes with bits 1 then 0 -> crc_reg=15'h4EAB.
- Then data_complete -> crc_bit sequence 1,0,0,1,1,1,0,1,0,1,0,1,0,1,1 over 15 sample_points.
- Then one delimiter bit 1, then crc_complete=1.
REQ-022 All-zero stream: 20 strobes with crc_bit_in=0 -> crc_reg=0.
- 15 zero bits are sent; crc_complete rises exactly 16 sample_points after SEND entry.
REQ-023 Abort: drop enable at bit_counter=7 in SEND -> next clock IDLE, bit_counter=0, crc_bit=1, crc_complete=0.
- Re-request -> crc_reg cleared to 0.
REQ-024 Simultaneous events: crc_bit_valid, data_complete and sample_point in the same cycle -> that bit is included in crc_reg, SEND is entered, and bit_counter stays 0.
REQ-025 Reset mid-DELIM: reset=1 -> all outputs at REQ-017 values on that edge.
- Tx_request held high -> ACCUM re-entered one clock after reset deasserts.
